rr_req_arbiter: RTL and testbench

RR_REQ_ARBITER -- requirements
Module: rr_req_arbiter

---
 rtl/rr_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_rr_req_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter
// Round-robin arbiter over N level requesters with a bounded hold time.
// A grant is registered one cycle after the request is sampled and is kept
// while the owner holds its request. If the owner has been served for
// MAX_HOLD cycles and someone else is waiting, the grant is revoked and
// preempt pulses. Every grant is followed by exactly one idle cycle, and the
// search for the next owner starts just after the previous owner.
//
// Ports
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset
//   req     : [N-1:0] level requests, held high until served
//   gnt     : [N-1:0] registered one-hot-or-zero grant
//   gnt_id  : index of the granted requester, 0 when gnt is 0
//   busy    : high whenever gnt is nonzero
//   preempt : one-cycle pulse in the idle cycle after a hold timeout
module rr_req_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 preempt
);

   localparam int         IW       = $clog2(N);
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_r, state_s;
   logic [IW-1:0]   ptr_r, ptr_s;
   logic [7:0]      hold_cnt_r, hold_cnt_s;
   logic [N-1:0]    gnt_r, gnt_s;
   logic [IW-1:0]   gnt_id_r, gnt_id_s;
   logic            busy_r, busy_s;
   logic            preempt_r, preempt_s;
   logic [IW-1:0]   pick_id_s;
   logic            owner_req_s;
   logic            others_s;

   // Increment an index modulo N.
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      if (v == IW'(N - 1)) begin
         r = {IW{1'b0}};
      end else begin
         r = v + IW'(1'b1);
      end
      return r;
   endfunction

   // First asserted request found scanning from p upward, wrapping at N.
   // Only meaningful when r is nonzero.
   function automatic logic [IW-1:0] rr_pick(input logic [N-1:0]  r,
                                             input logic [IW-1:0] p);
      logic [IW-1:0] idx;
      logic [IW-1:0] pick;
      logic          found;
      idx   = p;
      pick  = p;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            pick = pick;
         end
         idx = wrap_inc(idx);
      end
      return pick;
   endfunction

   // One-hot vector for an index.
   function automatic logic [N-1:0] one_hot(input logic [IW-1:0] id);
      logic [N-1:0] v;
      v     = {N{1'b0}};
      v[id] = 1'b1;
      return v;
   endfunction

   // Next-state and next-output logic of the arbitration FSM.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      hold_cnt_s  = hold_cnt_r;
      gnt_s       = gnt_r;
      gnt_id_s    = gnt_id_r;
      busy_s      = busy_r;
      preempt_s   = 1'b0;
      pick_id_s   = rr_pick(req, ptr_r);
      owner_req_s = req[gnt_id_r];
      // gnt_r is the owner's one-hot mask, so this is "anyone but the owner".
      others_s    = |(req & ~gnt_r);

      case (state_r)
         IDLE: begin
            if (|req) begin
               state_s    = GRANT;
               gnt_s      = one_hot(pick_id_s);
               gnt_id_s   = pick_id_s;
               busy_s     = 1'b1;
               hold_cnt_s = 8'd1;
            end else begin
               gnt_s      = {N{1'b0}};
               gnt_id_s   = {IW{1'b0}};
               busy_s     = 1'b0;
               hold_cnt_s = 8'd0;
            end
         end
         GRANT: begin
            // Release is checked first so a simultaneous timeout never pulses preempt.
            if (!owner_req_s) begin
               state_s    = IDLE;
               ptr_s      = wrap_inc(gnt_id_r);
               gnt_s      = {N{1'b0}};
               gnt_id_s   = {IW{1'b0}};
               busy_s     = 1'b0;
               hold_cnt_s = 8'd0;
            end else if ((hold_cnt_r == HOLD_MAX) && others_s) begin
               state_s    = IDLE;
               ptr_s      = wrap_inc(gnt_id_r);
               gnt_s      = {N{1'b0}};
               gnt_id_s   = {IW{1'b0}};
               busy_s     = 1'b0;
               hold_cnt_s = 8'd0;
               preempt_s  = 1'b1;
            end else if (hold_cnt_r < HOLD_MAX) begin
               hold_cnt_s = hold_cnt_r + 8'd1;
            end else begin
               // Saturated with nobody else waiting: keep serving the owner.
               hold_cnt_s = hold_cnt_r;
            end
         end
         default: begin
            state_s    = IDLE;
            ptr_s      = {IW{1'b0}};
            gnt_s      = {N{1'b0}};
            gnt_id_s   = {IW{1'b0}};
            busy_s     = 1'b0;
            hold_cnt_s = 8'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         ptr_r      <= {IW{1'b0}};
         hold_cnt_r <= 8'd0;
         gnt_r      <= {N{1'b0}};
         gnt_id_r   <= {IW{1'b0}};
         busy_r     <= 1'b0;
         preempt_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         hold_cnt_r <= hold_cnt_s;
         gnt_r      <= gnt_s;
         gnt_id_r   <= gnt_id_s;
         busy_r     <= busy_s;
         preempt_r  <= preempt_s;
      end
   end

   assign gnt     = gnt_r;
   assign gnt_id  = gnt_id_r;
   assign busy    = busy_r;
   assign preempt = preempt_r;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter
// Scenario tests for rr_req_arbiter (N=4, MAX_HOLD=8). Each test drives req
// on the falling edge, pushes the expected {gnt, gnt_id, busy, preempt} for
// that cycle onto a queue, and pops and compares just after the rising edge.
// Concurrent assertions watch grant legality and starvation throughout.
module tb_rr_req_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int BOUND    = (N - 1) * (MAX_HOLD + 1) + 1;

   typedef logic [7:0] exp_t;

   logic         clk;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;
   logic         preempt;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   int   wait_cnt [N];
   logic starve;

   rr_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id, input logic p);
      return {g, id, |g, p};
   endfunction

   // Per-requester count of consecutive cycles spent waiting.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset || !req[i] || gnt[i]) wait_cnt[i] <= 0;
         else                             wait_cnt[i] <= wait_cnt[i] + 1;
      end
   end

   always_comb begin
      starve = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (wait_cnt[i] > BOUND) starve = 1'b1;
      end
   end

   a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt))
      else begin bad++; $display("FAIL a_onehot gnt=%b", gnt); end

   a_req_prev: assert property (@(posedge clk) disable iff (reset) ((gnt & ~$past(req)) == 4'b0000))
      else begin bad++; $display("FAIL a_req_prev gnt=%b past_req=%b", gnt, $past(req)); end

   a_starve: assert property (@(posedge clk) disable iff (reset) !starve)
      else begin bad++; $display("FAIL a_starve wait=%0d/%0d/%0d/%0d bound=%0d",
                                  wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3], BOUND); end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = 4'b0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         reset = (k < 3);
         req   = (k < 3) ? 4'b1111 : 4'b0000;
         exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL reset k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   task automatic test_single_then_ptr();
      logic [3:0] rq [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                              4'b1111, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
      logic [3:0] eg [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                              4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      logic [1:0] ei [10] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
      exp_t e;
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         req = rq[k];
         exp_q.push_back(mk(eg[k], ei[k], 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL single k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] rq [15] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111,
                              4'b1101, 4'b1111, 4'b1111, 4'b1011, 4'b1111,
                              4'b1111, 4'b0111, 4'b1111, 4'b1110, 4'b0000};
      logic [3:0] eg [15] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                              4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000,
                              4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      logic [1:0] ei [15] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2,
                              2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      exp_t e;
      apply_reset();
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         req = rq[k];
         exp_q.push_back(mk(eg[k], ei[k], 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL rr k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      apply_reset();
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         req = {1'b0, (k >= 3 && k <= 11), 1'b0, (k < 20)};
         if (k <= 7)       exp_q.push_back(mk(4'b0001, 2'd0, 1'b0));
         else if (k == 8)  exp_q.push_back(mk(4'b0000, 2'd0, 1'b1));
         else if (k <= 11) exp_q.push_back(mk(4'b0100, 2'd2, 1'b0));
         else if (k == 12) exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
         else if (k <= 19) exp_q.push_back(mk(4'b0001, 2'd0, 1'b0));
         else              exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL timeout k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   task automatic test_long_hold();
      exp_t e;
      apply_reset();
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         req = {(k >= 20 && k <= 22), 1'b0, (k <= 21), 1'b0};
         if (k <= 19)      exp_q.push_back(mk(4'b0010, 2'd1, 1'b0));
         else if (k == 20) exp_q.push_back(mk(4'b0000, 2'd0, 1'b1));
         else if (k <= 22) exp_q.push_back(mk(4'b1000, 2'd3, 1'b0));
         else              exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL long_hold k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   task automatic test_release_at_timeout();
      exp_t e;
      apply_reset();
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         req = (k <= 7) ? 4'b0001 : ((k <= 9) ? 4'b0010 : 4'b0000);
         if (k <= 7)      exp_q.push_back(mk(4'b0001, 2'd0, 1'b0));
         else if (k == 8) exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
         else if (k == 9) exp_q.push_back(mk(4'b0010, 2'd1, 1'b0));
         else             exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL rel_tmo k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   task automatic test_mid_grant_reset();
      logic [3:0] rq [7] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b0000};
      logic [3:0] eg [7] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
      logic [1:0] ei [7] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
      exp_t e;
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         reset = (k == 2);
         req   = rq[k];
         exp_q.push_back(mk(eg[k], ei[k], 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if ({gnt, gnt_id, busy, preempt} !== e) begin
            bad++;
            $display("FAIL mid_reset k=%0d got=%b want=%b", k, {gnt, gnt_id, busy, preempt}, e);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      test_reset();
      test_single_then_ptr();
      test_round_robin();
      test_timeout();
      test_long_hold();
      test_release_at_timeout();
      test_mid_grant_reset();
      @(negedge clk);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
